// File: rtl/square_mover_pkg.sv
// Shared constants, slot layout and FSM encoding for the obstacle/player position producer.
package square_mover_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SQUARE_SIZE = 30;
  localparam int unsigned NUM_SLOTS   = 16;
  localparam int unsigned PLAYER_STEP = 4;
  localparam int unsigned PARK_XY     = 1000;

  localparam int unsigned SLOT_W     = 40;
  localparam int unsigned X_LSB      = 0;
  localparam int unsigned Y_LSB      = 10;
  localparam int unsigned ACTIVE_BIT = 20;
  localparam int unsigned SPD_LSB    = 21;
  localparam int unsigned DX_BIT     = 23;
  localparam int unsigned DY_BIT     = 24;
  localparam int unsigned PLAYER_LSB = NUM_SLOTS * SLOT_W;

  localparam logic [9:0]  X_LIM     = 10'(SCREEN_W - SQUARE_SIZE);
  localparam logic [9:0]  Y_LIM     = 10'(SCREEN_H - SQUARE_SIZE);
  localparam logic [9:0]  PLAYER_X0 = 10'd305;
  localparam logic [9:0]  PLAYER_Y0 = 10'd400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {StIdle, StSweep, StPlayer, StCommit} state_e;

  typedef struct packed {
    logic       dy;
    logic       dx;
    logic [1:0] spd;
    logic       active;
    logic [9:0] y;
    logic [9:0] x;
  } slot_t;

  localparam slot_t SLOT_PARK = '{dy: 1'b0, dx: 1'b0, spd: 2'd0, active: 1'b0,
                                  y: 10'(PARK_XY), x: 10'(PARK_XY)};

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
  } axis_t;

  // One axis of obstacle motion; landing exactly on an edge keeps the direction.
  function automatic axis_t move_axis(input logic [9:0] p, input logic dir,
                                      input logic [2:0] s, input logic [9:0] lim);
    axis_t       r;
    logic [10:0] sum;
    sum   = {1'b0, p} + {8'd0, s};
    r.pos = p;
    r.dir = dir;
    if (dir) begin
      if (sum > {1'b0, lim}) begin
        r.pos = lim;
        r.dir = 1'b0;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      if (p < {7'd0, s}) begin
        r.pos = '0;
        r.dir = 1'b1;
      end else begin
        r.pos = p - {7'd0, s};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/square_mover_lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, loads seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic fb;
  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= seed;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/square_mover.sv
// Per-frame obstacle sweep and player motion; position is committed atomically from shadows.
module square_mover
  import square_mover_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    refresh_tick,
  input  logic                    status,
  input  logic [5:0]              num_squares,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_up,
  input  logic                    btn_down,
  output logic [PLAYER_LSB+19:0]  position,
  output logic                    busy,
  output logic                    frame_done
);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic        spawn_q;
  slot_t       sh_q [NUM_SLOTS];
  slot_t       cm_q [NUM_SLOTS];
  logic [9:0]  px_sh_q, py_sh_q, px_q, py_q;
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .seed    (LFSR_SEED),
    .q       (lfsr_q)
  );

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q[15:12];

  logic [4:0] active_cnt;
  logic [6:0] req_cnt, target;
  logic       start_spawn;
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) active_cnt = active_cnt + 5'(cm_q[i].active);
    req_cnt     = 7'(num_squares) + 7'd1;
    target      = (req_cnt > 7'(NUM_SLOTS)) ? 7'(NUM_SLOTS) : req_cnt;
    start_spawn = ({2'b00, active_cnt} < target) && (py_q >= 10'(2 * SQUARE_SIZE));
  end

  // Single shared slot datapath, selected by the sweep index.
  slot_t      cur, slot_nx;
  axis_t      ax, ay;
  logic       do_spawn;
  logic [9:0] lfsr_x, spawn_x;
  always_comb begin
    cur      = sh_q[idx_q];
    do_spawn = spawn_q && !cur.active;
    lfsr_x   = {1'b0, lfsr_q[8:0]};
    spawn_x  = (lfsr_x > X_LIM) ? X_LIM : lfsr_x;
    ax       = move_axis(cur.x, cur.dx, {1'b0, cur.spd} + 3'd1, X_LIM);
    ay       = move_axis(cur.y, cur.dy, {1'b0, cur.spd} + 3'd1, Y_LIM);
    slot_nx  = cur;
    if (do_spawn) begin
      slot_nx = '{dy: 1'b1, dx: lfsr_q[11], spd: lfsr_q[10:9], active: 1'b1,
                  y: 10'd0, x: spawn_x};
    end else if (cur.active) begin
      slot_nx.x  = ax.pos;
      slot_nx.dx = ax.dir;
      slot_nx.y  = ay.pos;
      slot_nx.dy = ay.dir;
    end
  end

  logic        mv_l, mv_r, mv_u, mv_d;
  logic [10:0] px_sum, py_sum;
  logic [9:0]  px_nx, py_nx;
  always_comb begin
    mv_l   = btn_left & ~btn_right;
    mv_r   = btn_right & ~btn_left;
    mv_u   = btn_up & ~btn_down;
    mv_d   = btn_down & ~btn_up;
    px_sum = {1'b0, px_sh_q} + 11'(PLAYER_STEP);
    py_sum = {1'b0, py_sh_q} + 11'(PLAYER_STEP);
    px_nx  = px_sh_q;
    py_nx  = py_sh_q;
    if (mv_l)      px_nx = (px_sh_q < 10'(PLAYER_STEP)) ? '0 : px_sh_q - 10'(PLAYER_STEP);
    else if (mv_r) px_nx = (px_sum > {1'b0, X_LIM}) ? X_LIM : px_sum[9:0];
    if (mv_u)      py_nx = (py_sh_q < 10'(PLAYER_STEP)) ? '0 : py_sh_q - 10'(PLAYER_STEP);
    else if (mv_d) py_nx = (py_sum > {1'b0, Y_LIM}) ? Y_LIM : py_sum[9:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      spawn_q    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      px_sh_q    <= PLAYER_X0;
      py_sh_q    <= PLAYER_Y0;
      px_q       <= PLAYER_X0;
      py_q       <= PLAYER_Y0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sh_q[i] <= SLOT_PARK;
        cm_q[i] <= SLOT_PARK;
      end
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (refresh_tick && status) begin
            state_q <= StSweep;
            idx_q   <= '0;
            busy    <= 1'b1;
            spawn_q <= start_spawn;
          end
        end
        StSweep: begin
          sh_q[idx_q] <= slot_nx;
          if (do_spawn) spawn_q <= 1'b0;
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'(NUM_SLOTS - 1)) state_q <= StPlayer;
        end
        StPlayer: begin
          px_sh_q <= px_nx;
          py_sh_q <= py_nx;
          state_q <= StCommit;
        end
        StCommit: begin
          cm_q       <= sh_q;
          px_q       <= px_sh_q;
          py_q       <= py_sh_q;
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    position = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      position[i*SLOT_W + X_LSB +: 10]  = cm_q[i].x;
      position[i*SLOT_W + Y_LSB +: 10]  = cm_q[i].y;
      position[i*SLOT_W + ACTIVE_BIT]   = cm_q[i].active;
      position[i*SLOT_W + SPD_LSB +: 2] = cm_q[i].spd;
      position[i*SLOT_W + DX_BIT]       = cm_q[i].dx;
      position[i*SLOT_W + DY_BIT]       = cm_q[i].dy;
    end
    position[PLAYER_LSB +: 10]      = px_q;
    position[PLAYER_LSB + 10 +: 10] = py_q;
  end

endmodule

// File: tb/tb_square_mover.sv
// Directed bench for square_mover with a frame-level reference model of obstacles and player.
module tb_square_mover;
  import square_mover_pkg::*;

  logic         clk, reset_n, refresh_tick, status;
  logic [5:0]   num_squares;
  logic         btn_left, btn_right, btn_up, btn_down;
  logic [659:0] position;
  logic         busy, frame_done;

  int errors = 0;
  int checks = 0;

  int m_x [16], m_y [16], m_act [16], m_spd [16], m_dx [16], m_dy [16];
  int m_px, m_py;

  square_mover dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .refresh_tick (refresh_tick),
    .status       (status),
    .num_squares  (num_squares),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .position     (position),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mv(input int p, input int dir, input int s, input int lim,
                            output int nd);
    if (dir != 0) begin
      if (p + s > lim) begin nd = 0; return lim; end
      nd = 1;
      return p + s;
    end
    if (p < s) begin nd = 1; return 0; end
    nd = 0;
    return p - s;
  endfunction

  function automatic int dut_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(position[i*40+20]);
    return c;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 16; i++) begin
      m_x[i] = 1000; m_y[i] = 1000; m_act[i] = 0; m_spd[i] = 0; m_dx[i] = 0; m_dy[i] = 0;
    end
    m_px = 305;
    m_py = 400;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s_slot%0d", tag, i), position[i*40 +: 40], 64'd1025000);
    check_eq({tag, "_player"}, position[659:640], {10'd400, 10'd305});
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, frame_done, 0);
  endtask

  // Advance the model by one frame and compare it against the committed position.
  task automatic model_frame();
    int cnt, tgt, sp, nd;
    logic [39:0] f, e;
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += m_act[i];
    tgt = (int'(num_squares) + 1 > 16) ? 16 : int'(num_squares) + 1;
    sp = -1;
    if (cnt < tgt && m_py >= 60)
      for (int i = 0; i < 16; i++) if (m_act[i] == 0) begin sp = i; break; end
    for (int i = 0; i < 16; i++) begin
      if (m_act[i] != 0) begin
        m_x[i] = mv(m_x[i], m_dx[i], m_spd[i] + 1, 610, nd); m_dx[i] = nd;
        m_y[i] = mv(m_y[i], m_dy[i], m_spd[i] + 1, 450, nd); m_dy[i] = nd;
      end
    end
    if (btn_left && !btn_right)      m_px = (m_px < 4) ? 0 : m_px - 4;
    else if (btn_right && !btn_left) m_px = (m_px + 4 > 610) ? 610 : m_px + 4;
    if (btn_up && !btn_down)         m_py = (m_py < 4) ? 0 : m_py - 4;
    else if (btn_down && !btn_up)    m_py = (m_py + 4 > 450) ? 450 : m_py + 4;
    for (int i = 0; i < 16; i++) begin
      f = position[i*40 +: 40];
      if (i == sp) begin
        check_eq($sformatf("spawn%0d_y", i), f[19:10], 0);
        check_eq($sformatf("spawn%0d_dy", i), f[24], 1);
        check_eq($sformatf("spawn%0d_act", i), f[20], 1);
        check_eq($sformatf("spawn%0d_xrange", i), f[9:0] <= 10'd610, 1);
        check_eq($sformatf("spawn%0d_pad", i), f[39:25], 0);
        m_act[i] = 1; m_x[i] = int'(f[9:0]); m_y[i] = 0;
        m_spd[i] = int'(f[22:21]); m_dx[i] = int'(f[23]); m_dy[i] = 1;
      end else begin
        e = '0;
        e[9:0] = 10'(m_x[i]); e[19:10] = 10'(m_y[i]); e[20] = m_act[i][0];
        e[22:21] = 2'(m_spd[i]); e[23] = m_dx[i][0]; e[24] = m_dy[i][0];
        check_eq($sformatf("slot%0d", i), f, e);
      end
    end
    check_eq("player_x", position[649:640], m_px);
    check_eq("player_y", position[659:650], m_py);
  endtask

  // Called and returns on a negedge; pulses one tick and waits for frame_done.
  task automatic run_frame(output int lat, output int bc, output bit early);
    logic [659:0] snap;
    snap  = position;
    lat   = -1;
    bc    = 0;
    early = 1'b0;
    refresh_tick = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      refresh_tick = 1'b0;
      if (busy) bc++;
      if (frame_done) begin lat = k - 1; break; end
      if (position !== snap) early = 1'b1;
    end
    if (lat < 0) check_eq("frame_timeout", frame_done, 1);
  endtask

  task automatic frame_step();
    int lat, bc;
    bit early;
    run_frame(lat, bc, early);
    model_frame();
  endtask

  initial begin
    int lat, bc, dc, n;
    bit early, flag_b, flag_p;
    axis_t r;
    logic [659:0] snap;

    reset_n = 1'b0; refresh_tick = 1'b0; status = 1'b0; num_squares = 6'd0;
    btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");

    r = move_axis(10'd608, 1'b1, 3'd4, 10'd610);
    check_eq("bnc608_pos", r.pos, 610); check_eq("bnc608_dir", r.dir, 0);
    r = move_axis(10'd1, 1'b0, 3'd2, 10'd610);
    check_eq("bnc1_pos", r.pos, 0); check_eq("bnc1_dir", r.dir, 1);
    r = move_axis(10'd606, 1'b1, 3'd4, 10'd610);
    check_eq("exact610_pos", r.pos, 610); check_eq("exact610_dir", r.dir, 1);
    r = move_axis(10'd3, 1'b0, 3'd3, 10'd610);
    check_eq("exact0_pos", r.pos, 0); check_eq("exact0_dir", r.dir, 0);
    r = move_axis(10'd449, 1'b1, 3'd2, 10'd450);
    check_eq("bnc449_pos", r.pos, 450); check_eq("bnc449_dir", r.dir, 0);

    reset_n = 1'b1;
    model_init();
    status = 1'b1;
    @(negedge clk);

    run_frame(lat, bc, early);
    check_eq("latency", lat, 18);
    check_eq("busy_cycles", bc, 18);
    check_eq("early_change", early, 0);
    model_frame();
    check_eq("ramp_first", dut_count(), 1);
    frame_step();
    check_eq("ramp_hold", dut_count(), 1);

    num_squares = 6'd20;
    for (int f = 0; f < 17; f++) begin
      frame_step();
      check_eq($sformatf("ramp_cnt%0d", f), dut_count(), (f + 2 > 16) ? 16 : f + 2);
    end

    btn_down = 1'b1;
    for (int f = 0; f < 13; f++) frame_step();
    check_eq("down_clamp", position[659:650], 450);

    btn_left = 1'b1; btn_right = 1'b1; btn_up = 1'b1;
    for (int f = 0; f < 3; f++) frame_step();
    check_eq("lr_hold_x", position[649:640], 305);
    check_eq("ud_hold_y", position[659:650], 450);

    btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    for (int f = 0; f < 80; f++) frame_step();
    check_eq("left_clamp", position[649:640], 0);
    btn_left = 1'b0;

    // Second tick mid-sweep is dropped; collision mid-sweep does not abort the frame.
    dc = 0;
    refresh_tick = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      refresh_tick = 1'b0;
      if (k == 5) begin refresh_tick = 1'b1; status = 1'b0; end
      if (frame_done) dc++;
    end
    check_eq("drop_done_cnt", dc, 1);
    model_frame();

    snap = position; flag_b = 1'b0; flag_p = 1'b0; dc = 0;
    refresh_tick = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      refresh_tick = 1'b0;
      if (busy) flag_b = 1'b1;
      if (frame_done) dc++;
      if (position !== snap) flag_p = 1'b1;
    end
    check_eq("freeze_busy", flag_b, 0);
    check_eq("freeze_done", dc, 0);
    check_eq("freeze_pos", flag_p, 0);

    status = 1'b1;
    refresh_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      refresh_tick = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    dc = 0; flag_b = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (frame_done) dc++;
      if (busy) flag_b = 1'b1;
    end
    check_eq("midrst_done", dc, 0);
    check_eq("midrst_busy", flag_b, 0);

    model_init();
    num_squares = 6'd0;
    btn_up = 1'b1;
    n = 0;
    while (m_py >= 60 && n < 100) begin
      frame_step();
      n++;
    end
    check_eq("up_to_56", position[659:650], 56);
    btn_up = 1'b0;
    num_squares = 6'd5;
    frame_step();
    check_eq("defer_cnt", dut_count(), 1);
    btn_down = 1'b1;
    frame_step();
    check_eq("defer_cnt2", dut_count(), 1);
    btn_down = 1'b0;
    frame_step();
    check_eq("defer_release", dut_count(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
